// File: rtl/mac_rx_fcs_check.sv
// RX FCS checker: CRC-32 over the whole frame, strips the FCS and flags bad frames on the last beat.
// Latency 1 cycle per emitted beat (payload delayed 4 beats when stripping); no backpressure, PHY side never stalls.
module mac_rx_fcs_check #(
   parameter int          MIN_FRAME_LEN = 64,
   parameter bit          STRIP_FCS     = 1'b1,
   parameter logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3
) (
   input  logic       clk,
   input  logic       srstb,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser,
   output logic       stat_good,
   output logic       stat_bad_fcs,
   output logic       stat_runt
);

   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_FILL = 2'd1;
   localparam logic [1:0]  ST_PASS = 2'd2;
   localparam logic [16:0] MIN_LEN = 17'(MIN_FRAME_LEN);

   logic [31:0] crc;
   logic [31:0] crc_next;
   logic [15:0] cnt;
   logic [15:0] len;
   logic        err_seen;
   logic [1:0]  state;
   logic [31:0] pipe;
   logic        eof;
   logic        crc_ok;
   logic        runt;
   logic        bad;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
      end
      return r;
   endfunction

   assign crc_next = crc_byte(crc, s_axis_tdata);
   assign eof      = s_axis_tvalid & s_axis_tlast;
   // Length of the frame including the current beat, saturating.
   assign len      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   assign crc_ok   = (crc_next == CRC_RESIDUE);
   assign runt     = ({1'b0, len} < MIN_LEN);
   assign bad      = ~crc_ok | runt | err_seen | s_axis_tuser;

   always_ff @(posedge clk) begin
      if (srstb) begin
         crc           <= 32'hFFFF_FFFF;
         cnt           <= 16'd0;
         err_seen      <= 1'b0;
         state         <= ST_IDLE;
         pipe          <= 32'd0;
         m_axis_tdata  <= 8'd0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         stat_good     <= 1'b0;
         stat_bad_fcs  <= 1'b0;
         stat_runt     <= 1'b0;
      end else begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         stat_good     <= 1'b0;
         stat_bad_fcs  <= 1'b0;
         stat_runt     <= 1'b0;
         if (s_axis_tvalid) begin
            if (eof) begin
               crc          <= 32'hFFFF_FFFF;
               cnt          <= 16'd0;
               err_seen     <= 1'b0;
               stat_good    <= ~bad;
               stat_bad_fcs <= ~crc_ok;
               stat_runt    <= runt;
            end else begin
               crc      <= crc_next;
               cnt      <= len;
               err_seen <= err_seen | s_axis_tuser;
            end
            if (STRIP_FCS) begin
               // pipe[31:24] holds the oldest byte once four bytes are buffered.
               pipe <= eof ? 32'd0 : {pipe[23:0], s_axis_tdata};
               case (state)
                  ST_IDLE: state <= eof ? ST_IDLE : ST_FILL;
                  ST_FILL: begin
                     if (eof)
                        state <= ST_IDLE;
                     else if (cnt == 16'd3)
                        state <= ST_PASS;
                  end
                  default: begin
                     m_axis_tvalid <= 1'b1;
                     m_axis_tdata  <= pipe[31:24];
                     m_axis_tlast  <= eof;
                     m_axis_tuser  <= eof & bad;
                     if (eof)
                        state <= ST_IDLE;
                  end
               endcase
            end else begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= s_axis_tdata;
               m_axis_tlast  <= eof;
               m_axis_tuser  <= eof & bad;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Bench for mac_rx_fcs_check: three configurations share one input stream, checked per cycle against a frame-level model.
module tb_mac_rx_fcs_check;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       srstb;
   logic [7:0] s_tdata;
   logic       s_tvalid, s_tlast, s_tuser;

   logic [7:0] o_dat  [3];
   logic       o_vld  [3];
   logic       o_last [3];
   logic       o_user [3];
   logic       o_good [3];
   logic       o_bfcs [3];
   logic       o_runt [3];

   logic [7:0] e_dat  [3];
   logic       e_vld  [3];
   logic       e_last [3];
   logic       e_user [3];
   logic       e_good [3];
   logic       e_bfcs [3];
   logic       e_runt [3];

   int checks = 0;
   int errors = 0;
   int n_beats [3];
   int n_last  [3];
   int n_good  [3];
   int n_bfcs  [3];
   int n_runt  [3];
   bit chk_en = 1'b0;

   logic [7:0] frm_in [$];
   bit         err_in;
   logic [7:0] frm    [$];

   // dut 0: defaults; dut 1: no minimum length; dut 2: FCS forwarded
   mac_rx_fcs_check u_def (
      .clk(clk), .srstb(srstb),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(o_dat[0]), .m_axis_tvalid(o_vld[0]), .m_axis_tlast(o_last[0]), .m_axis_tuser(o_user[0]),
      .stat_good(o_good[0]), .stat_bad_fcs(o_bfcs[0]), .stat_runt(o_runt[0]));

   mac_rx_fcs_check #(.MIN_FRAME_LEN(0)) u_min0 (
      .clk(clk), .srstb(srstb),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(o_dat[1]), .m_axis_tvalid(o_vld[1]), .m_axis_tlast(o_last[1]), .m_axis_tuser(o_user[1]),
      .stat_good(o_good[1]), .stat_bad_fcs(o_bfcs[1]), .stat_runt(o_runt[1]));

   mac_rx_fcs_check #(.STRIP_FCS(1'b0)) u_nostrip (
      .clk(clk), .srstb(srstb),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(o_dat[2]), .m_axis_tvalid(o_vld[2]), .m_axis_tlast(o_last[2]), .m_axis_tuser(o_user[2]),
      .stat_good(o_good[2]), .stat_bad_fcs(o_bfcs[2]), .stat_runt(o_runt[2]));

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %h expected %h at %0t", name, idx, act, exp, $time);
      end
   endtask

   // CRC register after n bytes, init all-ones, no final inversion.
   function automatic logic [31:0] crc_reg(input logic [7:0] q[$], input int n);
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 8; b++)
            r = (r[0] ^ q[i][b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Frames of 4+ bytes: the trailer must equal the inverted payload CRC, LSB first.
   function automatic bit fcs_ok(input logic [7:0] q[$]);
      int n;
      n = q.size();
      if (n >= 4)
         return (~crc_reg(q, n - 4)) == {q[n-1], q[n-2], q[n-3], q[n-4]};
      return crc_reg(q, n) == 32'hDEBB20E3;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check("tvalid", i, 32'(o_vld[i]), 32'(e_vld[i]));
            if (e_vld[i]) begin
               check("tdata", i, 32'(o_dat[i]), 32'(e_dat[i]));
               check("tlast", i, 32'(o_last[i]), 32'(e_last[i]));
               if (e_last[i])
                  check("tuser", i, 32'(o_user[i]), 32'(e_user[i]));
            end
            check("stat_good", i, 32'(o_good[i]), 32'(e_good[i]));
            check("stat_bad_fcs", i, 32'(o_bfcs[i]), 32'(e_bfcs[i]));
            check("stat_runt", i, 32'(o_runt[i]), 32'(e_runt[i]));
            if (o_vld[i] === 1'b1) n_beats[i]++;
            if (o_vld[i] === 1'b1 && o_last[i] === 1'b1) n_last[i]++;
            if (o_good[i] === 1'b1) n_good[i]++;
            if (o_bfcs[i] === 1'b1) n_bfcs[i]++;
            if (o_runt[i] === 1'b1) n_runt[i]++;
         end
      end
   end

   task automatic cycle(input bit rst, input bit vld, input logic [7:0] d, input bit last, input bit user);
      int  k;
      bit  ok, bad64, bad0;
      @(negedge clk);
      srstb = rst; s_tvalid = vld; s_tdata = d; s_tlast = last; s_tuser = user;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         e_vld[i] = 0; e_dat[i] = 0; e_last[i] = 0; e_user[i] = 0;
         e_good[i] = 0; e_bfcs[i] = 0; e_runt[i] = 0;
      end
      if (rst) begin
         frm_in.delete();
         err_in = 0;
      end else if (vld) begin
         frm_in.push_back(d);
         err_in = err_in | user;
         k = frm_in.size() - 1;
         ok = 1; bad64 = 0; bad0 = 0;
         if (last) begin
            ok    = fcs_ok(frm_in);
            bad0  = !ok || err_in;
            bad64 = bad0 || (frm_in.size() < 64);
            e_good[0] = !bad64; e_bfcs[0] = !ok; e_runt[0] = frm_in.size() < 64;
            e_good[1] = !bad0;  e_bfcs[1] = !ok; e_runt[1] = 0;
            e_good[2] = !bad64; e_bfcs[2] = !ok; e_runt[2] = frm_in.size() < 64;
         end
         if (k >= 4) begin
            e_vld[0] = 1; e_dat[0] = frm_in[k-4]; e_last[0] = last; e_user[0] = bad64;
            e_vld[1] = 1; e_dat[1] = frm_in[k-4]; e_last[1] = last; e_user[1] = bad0;
         end
         e_vld[2] = 1; e_dat[2] = d; e_last[2] = last; e_user[2] = bad64;
         if (last) begin
            frm_in.delete();
            err_in = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 0);
   endtask

   task automatic clr_cnt();
      for (int i = 0; i < 3; i++) begin
         n_beats[i] = 0; n_last[i] = 0; n_good[i] = 0; n_bfcs[i] = 0; n_runt[i] = 0;
      end
   endtask

   task automatic make_good(input int plen);
      logic [31:0] c;
      frm.delete();
      for (int i = 0; i < plen; i++) frm.push_back(8'($urandom_range(255)));
      c = ~crc_reg(frm, plen);
      frm.push_back(c[7:0]); frm.push_back(c[15:8]); frm.push_back(c[23:16]); frm.push_back(c[31:24]);
   endtask

   // Sends frm; gap_pct: chance of idle cycles before each byte; rst_at: byte index replaced by a reset.
   task automatic send(input int gap_pct, input int err_idx, input int rst_at);
      for (int i = 0; i < frm.size(); i++) begin
         while (int'($urandom_range(99)) < gap_pct) idle(1);
         if (i == rst_at) begin
            cycle(1, 0, 8'h00, 0, 0);
            return;
         end
         cycle(0, 1, frm[i], i == frm.size() - 1, i == err_idx);
      end
   endtask

   initial begin
      srstb = 1; s_tvalid = 0; s_tdata = 0; s_tlast = 0; s_tuser = 0;
      err_in = 0;
      clr_cnt();
      cycle(1, 0, 8'h00, 0, 0);
      cycle(1, 0, 8'h00, 0, 0);
      chk_en = 1;
      idle(2);
      check("reset_tvalid", 0, 32'(o_vld[0]), 32'd0);
      check("reset_stat_good", 0, 32'(o_good[0]), 32'd0);

      // good 64-byte frame
      clr_cnt(); make_good(60); send(0, -1, -1); idle(2);
      check("t1_beats", 0, n_beats[0], 60);
      check("t1_last", 0, n_last[0], 1);
      check("t1_good", 0, n_good[0], 1);

      // FCS bit flipped
      clr_cnt(); make_good(60); frm[60] = frm[60] ^ 8'h01; send(0, -1, -1); idle(2);
      check("t2_beats", 0, n_beats[0], 60);
      check("t2_good", 0, n_good[0], 0);
      check("t2_bad_fcs", 0, n_bfcs[0], 1);

      // check string with known FCS
      clr_cnt();
      frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
      check("model_crc_check", 0, ~crc_reg(frm, 9), 32'hCBF43926);
      check("model_residue", 0, crc_reg(frm, 13), 32'hDEBB20E3);
      send(0, -1, -1); idle(2);
      check("t3_min0_beats", 1, n_beats[1], 9);
      check("t3_min0_good", 1, n_good[1], 1);
      check("t3_def_runt", 0, n_runt[0], 1);
      check("t3_def_good", 0, n_good[0], 0);
      check("t3_nostrip_beats", 2, n_beats[2], 13);

      // PHY error mid-frame with gaps
      clr_cnt(); make_good(60); send(30, 29, -1); idle(2);
      check("t4_beats", 0, n_beats[0], 60);
      check("t4_good", 0, n_good[0], 0);
      check("t4_bad_fcs", 0, n_bfcs[0], 0);
      check("t4_runt", 0, n_runt[0], 0);

      // back-to-back good frames then a 3-byte runt
      clr_cnt();
      make_good(60); send(0, -1, -1);
      make_good(60); send(0, -1, -1);
      frm.delete();
      for (int i = 0; i < 3; i++) frm.push_back(8'($urandom_range(255)));
      send(0, -1, -1); idle(2);
      check("t5_good", 0, n_good[0], 2);
      check("t5_last", 0, n_last[0], 2);
      check("t5_runt", 0, n_runt[0], 1);
      check("t5_nostrip_last", 2, n_last[2], 3);

      // reset mid-frame, then a good frame
      clr_cnt();
      make_good(60); send(0, -1, 20);
      make_good(60); send(0, -1, -1); idle(2);
      check("t6_beats", 0, n_beats[0], 76);
      check("t6_last", 0, n_last[0], 1);
      check("t6_good", 0, n_good[0], 1);
      check("t6_nostrip_beats", 2, n_beats[2], 84);

      // random frames: lengths, gaps, errors, corrupted FCS, occasional reset
      for (int f = 0; f < 30; f++) begin
         int plen;
         plen = int'($urandom_range(100));
         make_good(plen);
         if ($urandom_range(3) == 0) frm[$urandom_range(frm.size() - 1)] ^= 8'(1 << $urandom_range(7));
         if ($urandom_range(4) == 0) frm = frm[0:$urandom_range(3)];
         send(int'($urandom_range(40)),
              ($urandom_range(5) == 0) ? int'($urandom_range(frm.size() - 1)) : -1,
              ($urandom_range(9) == 0) ? int'($urandom_range(frm.size() - 1)) : -1);
         if ($urandom_range(1) == 0) idle(int'($urandom_range(3)));
      end
      idle(3);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
